yutorina_bus_if: RTL

Bus interface unit between a pipeline stage (IF or MEM) of `yutorina_cpu` and both the scratch-pad memory and the external arbitrated bus. One instance drives the CPU's `i_*` port group and another drives the `d_*` group. It decodes each access to SPM or bus and runs the request/grant/address-strobe/ready handshake. It raises `busy` so the controller stalls the pipeline until bus data returns.

---
 rtl/yutorina_bus_if_if.sv | 43 ++++
 rtl/yutorina_bus_if.sv | 129 ++++++++++++
 2 files changed

// File: rtl/yutorina_bus_if_if.sv
// Stage-side, SPM-side and bus-side signal bundle for yutorina_bus_if.
// master = the bus interface unit; slave = the stage, SPM and arbiter.
interface yutorina_bus_if_if #(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int SPM_ADDR_W = 12
);
    logic                  stall;
    logic                  flush;
    logic                  busy;
    logic [ADDR_W-1:0]     addr;
    logic                  as_;
    logic                  rw;
    logic [DATA_W-1:0]     w_data;
    logic [DATA_W-1:0]     r_data;
    logic [DATA_W-1:0]     spm_r_data;
    logic [SPM_ADDR_W-1:0] spm_addr;
    logic                  spm_as_;
    logic                  spm_rw;
    logic [DATA_W-1:0]     spm_w_data;
    logic [DATA_W-1:0]     bus_r_data;
    logic                  bus_rdy_;
    logic                  bus_grnt_;
    logic                  bus_req_;
    logic [ADDR_W-1:0]     bus_addr;
    logic                  bus_as_;
    logic                  bus_rw;
    logic [DATA_W-1:0]     bus_w_data;

    modport master (
        input  stall, flush, addr, as_, rw, w_data, spm_r_data,
               bus_r_data, bus_rdy_, bus_grnt_,
        output busy, r_data, spm_addr, spm_as_, spm_rw, spm_w_data,
               bus_req_, bus_addr, bus_as_, bus_rw, bus_w_data
    );

    modport slave (
        output stall, flush, addr, as_, rw, w_data, spm_r_data,
               bus_r_data, bus_rdy_, bus_grnt_,
        input  busy, r_data, spm_addr, spm_as_, spm_rw, spm_w_data,
               bus_req_, bus_addr, bus_as_, bus_rw, bus_w_data
    );
endinterface

// File: rtl/yutorina_bus_if.sv
// Pipeline-stage bus interface: SPM/bus decode plus req/grant/strobe/ready handshake.
// Define YUTORINA_BUS_IF_SPM_EN to enable the scratch-pad decode; otherwise all accesses use the bus.
module yutorina_bus_if #(
    parameter int       ADDR_W     = 30,
    parameter int       DATA_W     = 32,
    parameter int       SPM_ADDR_W = 12,
    parameter bit [2:0] SPM_IDX    = 3'd1
) (
    input  logic              clk,
    input  logic              rst,
    yutorina_bus_if_if.master bif
);
    typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_e;

    state_e              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_as_q, bus_as_d;
    logic                bus_rw_q, bus_rw_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]   rbuf_q, rbuf_d;

    logic                spm_hit;
    logic [DATA_W-1:0]   spm_rd;
    logic                acc_req;
    logic                busy_c;
    logic                spm_as_c;
    logic [DATA_W-1:0]   r_data_c;

`ifdef YUTORINA_BUS_IF_SPM_EN
    assign spm_hit         = (bif.addr[ADDR_W-1:ADDR_W-3] == SPM_IDX);
    assign spm_rd          = bif.spm_r_data;
    assign bif.spm_addr    = bif.addr[SPM_ADDR_W-1:0];
    assign bif.spm_rw      = bif.rw;
    assign bif.spm_w_data  = bif.w_data;
`else
    assign spm_hit         = 1'b0;
    assign spm_rd          = '0;
    assign bif.spm_addr    = '0;
    assign bif.spm_rw      = 1'b1;
    assign bif.spm_w_data  = '0;
`endif

    // Gated by rst so the combinational outputs stay quiet while reset is held.
    assign acc_req = rst && !bif.as_ && !bif.flush;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_as_d    = bus_as_q;
        bus_rw_d    = bus_rw_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rbuf_d      = rbuf_q;
        busy_c      = 1'b0;
        spm_as_c    = 1'b1;
        r_data_c    = '0;
        case (state_q)
            IDLE: begin
                if (acc_req) begin
                    if (spm_hit) begin
                        spm_as_c = 1'b0;
                        r_data_c = spm_rd;
                    end else begin
                        busy_c      = 1'b1;
                        bus_req_d   = 1'b0;
                        bus_addr_d  = bif.addr;
                        bus_rw_d    = bif.rw;
                        bus_wdata_d = bif.w_data;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                busy_c = 1'b1;
                if (!bif.bus_grnt_) begin
                    bus_as_d = 1'b0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                // Strobe is a single-cycle pulse regardless of ready latency.
                bus_as_d = 1'b1;
                if (!bif.bus_rdy_) begin
                    r_data_c  = bus_rw_q ? bif.bus_r_data : '0;
                    rbuf_d    = r_data_c;
                    bus_req_d = 1'b1;
                    state_d   = bif.stall ? WAIT : IDLE;
                end else begin
                    busy_c = 1'b1;
                end
            end
            WAIT: begin
                r_data_c = rbuf_q;
                if (!bif.stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b1;
            bus_as_q    <= 1'b1;
            bus_rw_q    <= 1'b1;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rbuf_q      <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_as_q    <= bus_as_d;
            bus_rw_q    <= bus_rw_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rbuf_q      <= rbuf_d;
        end
    end

    assign bif.busy       = busy_c;
    assign bif.r_data     = r_data_c;
    assign bif.spm_as_    = spm_as_c;
    assign bif.bus_req_   = bus_req_q;
    assign bif.bus_as_    = bus_as_q;
    assign bif.bus_rw     = bus_rw_q;
    assign bif.bus_addr   = bus_addr_q;
    assign bif.bus_w_data = bus_wdata_q;
endmodule
